spi_flash_shifter: RTL and testbench



---
 rtl/spi_flash_shifter.sv | 187 ++++++++++++++++++
 tb/tb_spi_flash_shifter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_shifter.sv
// Byte-level mode-0 SPI master for the configuration flash.
// Shifts one byte per request and optionally releases chip select afterwards.
module spi_flash_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    input  logic       req_last,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       sck_o,
    output logic       sck_t,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECTED,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             last_q, last_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [7:0]       resp_data_q, resp_data_d;
    logic             sck_o_q, sck_o_d;
    logic             sck_t_q, sck_t_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;

    logic div_wrap;
    logic accept;

    assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    assign accept   = req_valid && req_ready_q;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        done_d       = 1'b0;
        tx_d         = tx_q;
        rx_d         = rx_q;
        last_d       = last_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        sck_o_d      = sck_o_q;
        sck_t_d      = sck_t_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;

        case (state_q)
            IDLE, SELECTED: begin
                if (accept) begin
                    state_d     = SHIFT;
                    tx_d        = req_data;
                    last_d      = req_last;
                    cs_n_d      = 1'b0;
                    sck_t_d     = 1'b0;
                    sck_o_d     = 1'b0;
                    mosi_d      = req_data[7];
                    div_d       = '0;
                    bit_cnt_d   = 3'd0;
                    req_ready_d = 1'b0;
                end else begin
                    req_ready_d = 1'b1;
                    if (state_q == IDLE) begin
                        cs_n_d  = 1'b1;
                        sck_t_d = 1'b1;
                    end
                end
            end

            // Rising SCK samples miso; falling SCK advances mosi or completes the byte.
            SHIFT: begin
                if (div_wrap) begin
                    div_d   = '0;
                    sck_o_d = ~sck_o_q;
                    if (!sck_o_q) begin
                        rx_d = {rx_q[6:0], miso};
                    end else if (bit_cnt_q == 3'd7) begin
                        done_d       = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_data_d  = rx_q;
                        div_d        = '0;
                        if (last_q) begin
                            state_d     = CS_HOLD;
                            req_ready_d = 1'b0;
                        end else begin
                            state_d     = SELECTED;
                            req_ready_d = 1'b1;
                        end
                    end else begin
                        mosi_d    = tx_q[3'd6 - bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            CS_HOLD: begin
                if (div_wrap) begin
                    state_d = CS_GAP;
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    sck_t_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            CS_GAP: begin
                if (div_wrap) begin
                    state_d     = IDLE;
                    div_d       = '0;
                    req_ready_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_cnt_q    <= 3'd0;
            done_q       <= 1'b0;
            tx_q         <= 8'h00;
            rx_q         <= 8'h00;
            last_q       <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            sck_o_q      <= 1'b0;
            sck_t_q      <= 1'b1;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            done_q       <= done_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            last_q       <= last_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            sck_o_q      <= sck_o_d;
            sck_t_q      <= sck_t_d;
            cs_n_q       <= cs_n_d;
            mosi_q       <= mosi_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q && done_q;
    assign resp_data  = resp_data_q;
    assign sck_o      = sck_o_q;
    assign sck_t      = sck_t_q;
    assign cs_n       = cs_n_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_flash_shifter.sv
// Randomized self-checking bench for spi_flash_shifter.
// Three instances cover CLK_DIV = 1, 2 and 3 against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_spi_flash_shifter;

    logic       clk;
    logic       rst;
    logic       req_valid  [3];
    logic       req_ready  [3];
    logic [7:0] req_data   [3];
    logic       req_last   [3];
    logic       resp_valid [3];
    logic [7:0] resp_data  [3];
    logic       sck_o      [3];
    logic       sck_t      [3];
    logic       cs_n       [3];
    logic       mosi       [3];
    logic       miso_w     [3];
    logic       miso_drv   [3];
    logic       loop_en    [3];

    int  checks;
    int  errors;
    int  resp_count     [3];
    int  exp_resp_count [3];
    time prev_e0        [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign miso_w[g] = loop_en[g] ? mosi[g] : miso_drv[g];
        spi_flash_shifter #(.CLK_DIV(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_data  (req_data[g]),
            .req_last  (req_last[g]),
            .resp_valid(resp_valid[g]),
            .resp_data (resp_data[g]),
            .sck_o     (sck_o[g]),
            .sck_t     (sck_t[g]),
            .cs_n      (cs_n[g]),
            .mosi      (mosi[g]),
            .miso      (miso_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[i] === 1'b1) resp_count[i]++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // mode: 0 loopback, 1 miso tied high, 2 miso tied low, 3 miso driven with mbyte
    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last,
                                 input int mode, input logic [7:0] mbyte, input bit keep,
                                 input int gap_expect);
        int d;
        int nend;
        int w;
        logic [7:0] expb;
        logic exp_sck, exp_mosi, exp_cs, exp_ready;
        d    = idx + 1;
        expb = (mode == 0) ? data : (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : mbyte;
        loop_en[idx]   = (mode == 0);
        miso_drv[idx]  = (mode == 1);
        req_valid[idx] = 1'b1;
        req_data[idx]  = data;
        req_last[idx]  = last;
        w = 0;
        while (req_ready[idx] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (req_ready[idx] !== 1'b1) begin
            checkOutput($sformatf("i%0d ready_timeout", idx), 32'(req_ready[idx]), 32'd1);
            req_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        if (gap_expect > 0)
            checkOutput($sformatf("i%0d accept_gap", idx), 32'(($time - prev_e0[idx]) / 10), 32'(gap_expect));
        prev_e0[idx] = $time;
        exp_resp_count[idx]++;
        nend = last ? 18 * d : 16 * d;
        for (int n = 0; n <= nend; n++) begin
            @(negedge clk);
            if (n == 0 && !keep) req_valid[idx] = 1'b0;
            if (mode == 3 && n < 16 * d) miso_drv[idx] = mbyte[7 - n / (2 * d)];
            exp_sck   = (n < 16 * d) && ((n / d) % 2 == 1);
            exp_mosi  = (n < 16 * d) ? data[7 - n / (2 * d)] : data[0];
            exp_cs    = last && (n >= 17 * d);
            exp_ready = last ? (n >= 18 * d) : (n >= 16 * d);
            checkOutput($sformatf("i%0d n%0d sck_o", idx, n), 32'(sck_o[idx]), 32'(exp_sck));
            checkOutput($sformatf("i%0d n%0d mosi", idx, n), 32'(mosi[idx]), 32'(exp_mosi));
            checkOutput($sformatf("i%0d n%0d cs_n", idx, n), 32'(cs_n[idx]), 32'(exp_cs));
            checkOutput($sformatf("i%0d n%0d sck_t", idx, n), 32'(sck_t[idx]), 32'(exp_cs));
            checkOutput($sformatf("i%0d n%0d req_ready", idx, n), 32'(req_ready[idx]), 32'(exp_ready));
            checkOutput($sformatf("i%0d n%0d resp_valid", idx, n), 32'(resp_valid[idx]), 32'(n == 16 * d));
            if (n >= 16 * d)
                checkOutput($sformatf("i%0d n%0d resp_data", idx, n), 32'(resp_data[idx]), 32'(expb));
        end
    endtask

    task automatic checkIdleAll(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s i%0d sck_o", tag, i), 32'(sck_o[i]), 32'd0);
            checkOutput($sformatf("%s i%0d sck_t", tag, i), 32'(sck_t[i]), 32'd1);
            checkOutput($sformatf("%s i%0d cs_n", tag, i), 32'(cs_n[i]), 32'd1);
            checkOutput($sformatf("%s i%0d resp_valid", tag, i), 32'(resp_valid[i]), 32'd0);
        end
    endtask

    initial begin
        int w;
        int idx;
        int len;
        logic [7:0] b;
        logic lastb;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_data[i]  = 8'h00;
            req_last[i]  = 1'b0;
            miso_drv[i]  = 1'b0;
            loop_en[i]   = 1'b0;
            resp_count[i]     = 0;
            exp_resp_count[i] = 0;
            prev_e0[i]        = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset i%0d req_ready", i), 32'(req_ready[i]), 32'd0);
            checkOutput($sformatf("reset i%0d resp_data", i), 32'(resp_data[i]), 32'd0);
            checkOutput($sformatf("reset i%0d mosi", i), 32'(mosi[i]), 32'd0);
        end
        checkIdleAll("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed transfers");
        applyStimulus(1, 8'hA5, 1'b1, 0, 8'h00, 1'b0, 0);
        applyStimulus(1, 8'h03, 1'b0, 0, 8'h00, 1'b1, 0);
        applyStimulus(1, 8'h00, 1'b0, 2, 8'h00, 1'b1, 33);
        applyStimulus(1, 8'h7E, 1'b1, 0, 8'h00, 1'b0, 33);
        applyStimulus(0, 8'h00, 1'b1, 1, 8'h00, 1'b0, 0);
        applyStimulus(2, 8'h3C, 1'b1, 3, 8'h96, 1'b0, 0);

        $display("[TB] idle hold");
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checkIdleAll($sformatf("idle c%0d", c));
        end

        $display("[TB] reset mid-byte");
        req_valid[1] = 1'b1;
        req_data[1]  = 8'hC3;
        req_last[1]  = 1'b1;
        loop_en[1]   = 1'b1;
        w = 0;
        while (req_ready[1] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("rst_test ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("rst_test cs_low", 32'(cs_n[1]), 32'd0);
        repeat (9) @(posedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_test cs_n", 32'(cs_n[1]), 32'd1);
        checkOutput("rst_test sck_o", 32'(sck_o[1]), 32'd0);
        checkOutput("rst_test sck_t", 32'(sck_t[1]), 32'd1);
        checkOutput("rst_test req_ready", 32'(req_ready[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkIdleAll("post_rst");
        applyStimulus(1, 8'h5A, 1'b1, 0, 8'h00, 1'b0, 0);

        $display("[TB] random transfers");
        for (int r = 0; r < 20; r++) begin
            idx = $urandom_range(0, 2);
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                b     = 8'($urandom);
                lastb = (k == len - 1) ? 1'($urandom) : 1'b0;
                applyStimulus(idx, b, lastb, $urandom_range(0, 3), 8'($urandom),
                              k != len - 1, (k == 0) ? 0 : 16 * (idx + 1) + 1);
            end
        end

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("i%0d resp_count", i), 32'(resp_count[i]), 32'(exp_resp_count[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
